// File: rtl/writeback_queue_if.sv
// Bundle of the write-back queue's producer, drain and forwarding signals.
// master: the side that drives results, drain_en and lookup addresses.
// slave: the queue itself.
interface writeback_queue_if #(
    parameter int N     = 24,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_valid;
    logic          mem_ready;
    logic [3:0]    mem_addr;
    logic [N-1:0]  mem_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [3:0]    alu_addr;
    logic [N-1:0]  alu_data;
    logic          drain_en;
    logic [N-1:0]  pc_plus8;
    logic [3:0]    A3;
    logic [N-1:0]  WD3;
    logic          WE3;
    logic [N-1:0]  R15;
    logic [3:0]    fwd_addr1;
    logic [3:0]    fwd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [N-1:0]  fwd_data1;
    logic [N-1:0]  fwd_data2;
    logic [CW-1:0] count;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output drain_en, pc_plus8, fwd_addr1, fwd_addr2,
        input  mem_ready, alu_ready, A3, WD3, WE3, R15,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  drain_en, pc_plus8, fwd_addr1, fwd_addr2,
        output mem_ready, alu_ready, A3, WD3, WE3, R15,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order write-back FIFO between execute/memory and the register file.
// Accepts up to two results per cycle (mem older than ALU), drains one per
// cycle onto A3/WD3/WE3/R15 and answers two forwarding lookups.
module writeback_queue #(
    parameter int N     = 24,
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    writeback_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [3:0]    r_addr [DEPTH];
    logic [N-1:0]  r_data [DEPTH];

    logic [CW-1:0] w_free;
    logic          w_mem_ready;
    logic          w_alu_ready;
    logic          w_mem_push;
    logic          w_alu_push;
    logic [1:0]    w_push_cnt;
    logic [AW-1:0] w_alu_slot;
    logic          w_occupied;
    logic          w_pop;
    logic [3:0]    w_a3;
    logic [N-1:0]  w_wd3;
    logic [3:0]    w_fwd_addr [2];

    // Space is judged on registered occupancy only; a pop this cycle does
    // not make room for a push this cycle.
    assign w_free      = CW'(DEPTH) - r_count;
    assign w_mem_ready = (w_free >= CW'(1));
    assign w_alu_ready = (w_free >= CW'(2)) | (w_mem_ready & ~bus.mem_valid);

    // Writes to register 0 complete the handshake but are dropped.
    assign w_mem_push = bus.mem_valid & w_mem_ready & (bus.mem_addr != 4'd0);
    assign w_alu_push = bus.alu_valid & w_alu_ready & (bus.alu_addr != 4'd0);
    assign w_push_cnt = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    // ALU lands behind a stored mem result, so mem is always older.
    assign w_alu_slot = r_tail + AW'(w_mem_push);

    assign w_occupied = (r_count != '0);
    assign w_pop      = w_occupied & bus.drain_en;
    assign w_a3       = w_occupied ? r_addr[r_head] : 4'd0;
    assign w_wd3      = w_occupied ? r_data[r_head] : '0;

    assign bus.mem_ready = w_mem_ready;
    assign bus.alu_ready = w_alu_ready;
    assign bus.WE3       = w_pop;
    assign bus.A3        = w_a3;
    assign bus.WD3       = w_wd3;
    assign bus.R15       = (w_pop && (w_a3 == 4'd15)) ? w_wd3 : bus.pc_plus8;
    assign bus.count     = r_count;

    // Pointers and occupancy; reset discards everything pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_push_cnt);
            r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop);
        end
    end

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_mem_push) begin
            r_addr[r_tail] <= bus.mem_addr;
            r_data[r_tail] <= bus.mem_data;
        end
        if (w_alu_push) begin
            r_addr[w_alu_slot] <= bus.alu_addr;
            r_data[w_alu_slot] <= bus.alu_data;
        end
    end

    assign w_fwd_addr[0] = bus.fwd_addr1;
    assign w_fwd_addr[1] = bus.fwd_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic         w_hit;
            logic [N-1:0] w_data;

            // Walk oldest to youngest so the youngest match wins.
            always_comb begin
                logic [AW-1:0] v_idx;
                w_hit  = 1'b0;
                w_data = '0;
                v_idx  = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    v_idx = r_head + AW'(j);
                    if ((CW'(j) < r_count) && (w_fwd_addr[gi] != 4'd0) &&
                        (r_addr[v_idx] == w_fwd_addr[gi])) begin
                        w_hit  = 1'b1;
                        w_data = r_data[v_idx];
                    end
                end
            end
        end
    endgenerate

    assign bus.fwd_hit1  = g_fwd[0].w_hit;
    assign bus.fwd_data1 = g_fwd[0].w_data;
    assign bus.fwd_hit2  = g_fwd[1].w_hit;
    assign bus.fwd_data2 = g_fwd[1].w_data;
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the write-back FIFO.
module tb_writeback_queue;
    localparam int N     = 24;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]   addr;
        logic [N-1:0] data;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    writeback_queue_if #(.N(N), .DEPTH(DEPTH)) bus();

    writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Youngest pending entry with the given address; register 0 never hits.
    function automatic void model_fwd(input logic [3:0] a, output logic hit, output logic [N-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 4'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        int           free;
        logic         we;
        logic [3:0]   a3;
        logic [N-1:0] wd3;
        logic         h1, h2;
        logic [N-1:0] d1, d2;
        free = DEPTH - q.size();
        we   = (q.size() != 0) && bus.drain_en;
        a3   = (q.size() != 0) ? q[0].addr : 4'd0;
        wd3  = (q.size() != 0) ? q[0].data : '0;
        model_fwd(bus.fwd_addr1, h1, d1);
        model_fwd(bus.fwd_addr2, h2, d2);
        check_val("count", 32'(bus.count), 32'(q.size()));
        check_val("mem_ready", 32'(bus.mem_ready), 32'(free >= 1));
        check_val("alu_ready", 32'(bus.alu_ready), 32'((free >= 2) || ((free >= 1) && !bus.mem_valid)));
        check_val("WE3", 32'(bus.WE3), 32'(we));
        check_val("A3", 32'(bus.A3), 32'(a3));
        check_val("WD3", 32'(bus.WD3), 32'(wd3));
        check_val("R15", 32'(bus.R15), 32'((we && a3 == 4'd15) ? wd3 : bus.pc_plus8));
        check_val("fwd_hit1", 32'(bus.fwd_hit1), 32'(h1));
        check_val("fwd_data1", 32'(bus.fwd_data1), 32'(d1));
        check_val("fwd_hit2", 32'(bus.fwd_hit2), 32'(h2));
        check_val("fwd_data2", 32'(bus.fwd_data2), 32'(d2));
    endtask

    // One clock: check outputs mid-cycle, then apply the model's pop/pushes.
    task automatic step();
        int   free;
        logic mem_hs, alu_hs, we;
        ent_t me, ae;
        #1;
        check_outputs();
        free   = DEPTH - q.size();
        mem_hs = bus.mem_valid && (free >= 1);
        alu_hs = bus.alu_valid && ((free >= 2) || ((free >= 1) && !bus.mem_valid));
        we     = (q.size() != 0) && bus.drain_en;
        me.addr = bus.mem_addr;
        me.data = bus.mem_data;
        ae.addr = bus.alu_addr;
        ae.data = bus.alu_data;
        @(posedge clk);
        if (we) begin
            $display("drain a3=%0d wd3=%h pending=%0d", q[0].addr, q[0].data, q.size() - 1);
            void'(q.pop_front());
        end
        if (mem_hs && me.addr != 4'd0) q.push_back(me);
        if (alu_hs && ae.addr != 4'd0) q.push_back(ae);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    task automatic push_mem(input logic [3:0] a, input logic [N-1:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_data  = d;
    endtask

    task automatic push_alu(input logic [3:0] a, input logic [N-1:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    task automatic drain_all();
        bus.drain_en = 1'b1;
        idle();
        for (int i = 0; i < DEPTH + 1; i++) step();
    endtask

    initial begin
        idle();
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.drain_en  = 1'b1;
        bus.pc_plus8  = 24'h123456;
        bus.fwd_addr1 = 4'd4;
        bus.fwd_addr2 = 4'd15;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_WE3", 32'(bus.WE3), 32'd0);
        check_val("rst_A3", 32'(bus.A3), 32'd0);
        check_val("rst_WD3", 32'(bus.WD3), 32'd0);
        check_val("rst_R15", 32'(bus.R15), 32'h123456);
        check_val("rst_hit1", 32'(bus.fwd_hit1), 32'd0);
        check_val("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        check_val("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ALU write, drained the next cycle
        push_alu(4'd4, 24'h00ABCD);
        step();
        idle();
        #1;
        check_val("t1_WE3", 32'(bus.WE3), 32'd1);
        check_val("t1_A3", 32'(bus.A3), 32'd4);
        check_val("t1_WD3", 32'(bus.WD3), 32'h00ABCD);
        check_val("t1_R15", 32'(bus.R15), 32'h123456);
        step();
        check_val("t1_count_after", 32'(bus.count), 32'd0);
        step();

        // Dual push ordering: mem older than ALU
        bus.drain_en = 1'b0;
        push_mem(4'd5, 24'h111111);
        push_alu(4'd6, 24'h222222);
        step();
        idle();
        check_val("t2_count", 32'(bus.count), 32'd2);
        bus.drain_en = 1'b1;
        #1;
        check_val("t2_first_A3", 32'(bus.A3), 32'd5);
        step();
        check_val("t2_second_A3", 32'(bus.A3), 32'd6);
        step();
        step();

        // Backpressure: fill to DEPTH, then drain one per cycle
        bus.drain_en = 1'b0;
        push_mem(4'd1, 24'h000011);
        push_alu(4'd2, 24'h000022);
        step();
        push_mem(4'd3, 24'h000033);
        push_alu(4'd8, 24'h000088);
        step();
        #1;
        check_val("t3_count_full", 32'(bus.count), 32'd4);
        check_val("t3_mem_ready_full", 32'(bus.mem_ready), 32'd0);
        check_val("t3_alu_ready_full", 32'(bus.alu_ready), 32'd0);
        bus.drain_en = 1'b1;
        #1;
        check_val("t3_full_while_drain", 32'(bus.mem_ready), 32'd0);
        step();
        step();
        idle();
        drain_all();

        // Forwarding: youngest match wins, register 0 never hits
        bus.drain_en  = 1'b0;
        bus.fwd_addr1 = 4'd7;
        bus.fwd_addr2 = 4'd0;
        push_alu(4'd7, 24'h000001);
        step();
        push_alu(4'd7, 24'h000002);
        step();
        push_mem(4'd7, 24'h000003);
        #1;
        check_val("t4_hit1", 32'(bus.fwd_hit1), 32'd1);
        check_val("t4_data1_not_incoming", 32'(bus.fwd_data1), 32'h000002);
        check_val("t4_hit2", 32'(bus.fwd_hit2), 32'd0);
        step();
        idle();
        drain_all();

        // Register 0 dropped; r15 write routed to R15
        bus.drain_en = 1'b1;
        push_alu(4'd0, 24'hFFFFFF);
        step();
        idle();
        check_val("t5_zero_count", 32'(bus.count), 32'd0);
        push_alu(4'd15, 24'h000100);
        step();
        idle();
        #1;
        check_val("t5_WE3", 32'(bus.WE3), 32'd1);
        check_val("t5_R15", 32'(bus.R15), 32'h000100);
        step();

        // Asynchronous reset mid-operation
        bus.drain_en = 1'b0;
        push_mem(4'd9, 24'h000909);
        push_alu(4'd10, 24'h000A0A);
        step();
        idle();
        push_alu(4'd11, 24'h000B0B);
        step();
        idle();
        check_val("t6_count_pre", 32'(bus.count), 32'd3);
        bus.drain_en  = 1'b1;
        bus.fwd_addr1 = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_val("t6_rst_count", 32'(bus.count), 32'd0);
        check_val("t6_rst_WE3", 32'(bus.WE3), 32'd0);
        check_val("t6_rst_hit1", 32'(bus.fwd_hit1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_alu(4'd12, 24'h000C0C);
        step();
        idle();
        check_val("t6_post_count", 32'(bus.count), 32'd1);
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.mem_valid = ($urandom_range(0, 1) == 1);
            bus.mem_addr  = 4'($urandom_range(0, 15));
            bus.mem_data  = N'($urandom);
            bus.alu_valid = ($urandom_range(0, 1) == 1);
            bus.alu_addr  = 4'($urandom_range(0, 15));
            bus.alu_data  = N'($urandom);
            bus.drain_en  = ($urandom_range(0, 3) != 0);
            bus.pc_plus8  = N'($urandom);
            bus.fwd_addr1 = 4'($urandom_range(0, 15));
            bus.fwd_addr2 = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
